// File: rtl/conv_result_collector.sv
// rtl/conv_result_collector.sv - collects kernel-array window results and serializes them lane by lane.
// Optional ReLU clamp at capture: define CONV_COLLECTOR_RELU_EN.
module conv_result_collector #(
  parameter int ARRAY_SIZE  = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int PIPE_LAT    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus,
  input  logic                             i_mac_valid,
  output logic                             o_mac_ready,
  output logic                             o_clear,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  output logic                             o_last,
  input  logic                             i_ready
);

  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BEAT_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int LAT_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int IDX_W  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(KK - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(PIPE_LAT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, CLEAR} state_t;

  state_t                 state, state_nxt;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [DATA_WIDTH-1:0]  shadow [ARRAY_SIZE];
  logic                   full;
  logic [IDX_W-1:0]       idx;
  logic                   beat_acc, hs, last_hs, free, capture;

  function automatic logic [DATA_WIDTH-1:0] store_lane(input logic [DATA_WIDTH-1:0] v);
`ifdef CONV_COLLECTOR_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // A capture may reuse the shadow in the same cycle its final lane leaves.
  always_comb begin
    beat_acc  = (state == ACCUM) & i_mac_valid;
    hs        = full & i_ready;
    last_hs   = hs & (idx == IDX_LAST);
    free      = ~full | last_hs;
    capture   = (state == DRAIN) & (lat_cnt == LAT_LAST) & free;
    state_nxt = state;
    case (state)
      ACCUM:   if (beat_acc && beat_cnt == BEAT_LAST) state_nxt = DRAIN;
      DRAIN:   if (capture) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      full     <= 1'b0;
      idx      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: begin
          if (beat_acc) begin
            if (beat_cnt == BEAT_LAST) lat_cnt <= '0;
            else                       beat_cnt <= beat_cnt + 1'b1;
          end
        end
        DRAIN:   if (lat_cnt != LAT_LAST) lat_cnt <= lat_cnt + 1'b1;
        CLEAR:   beat_cnt <= '0;
        default: ;
      endcase
      if (capture) begin
        full <= 1'b1;
        idx  <= '0;
      end else if (last_hs) begin
        full <= 1'b0;
      end else if (hs) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Lane 0 sits in the most significant slice of the bus.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < ARRAY_SIZE; i++)
        shadow[i] <= store_lane(i_pixel_bus[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign o_mac_ready = ~rst & (state == ACCUM);
  assign o_clear     = ~rst & (state == CLEAR);
  assign o_valid     = ~rst & full;
  assign o_last      = ~rst & full & (idx == IDX_LAST);
  assign o_data      = (~rst & full) ? shadow[idx] : '0;

endmodule

// File: tb/tb_conv_result_collector.sv
// tb/tb_conv_result_collector.sv - self-checking bench for conv_result_collector.
module tb_conv_result_collector;

  localparam int AS = 6;
  localparam int DW = 16;
  localparam int KK = 9;
  localparam int PL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [AS*DW-1:0] i_pixel_bus;
  logic             i_mac_valid;
  logic             i_ready;
  logic             o_mac_ready, o_clear, o_valid, o_last;
  logic [DW-1:0]    o_data;
  logic             p1_mac_ready, p1_clear, p1_valid, p1_last;
  logic [DW-1:0]    p1_data;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  conv_result_collector #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .KERNEL_SIZE(3), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .i_pixel_bus(i_pixel_bus), .i_mac_valid(i_mac_valid),
    .o_mac_ready(o_mac_ready), .o_clear(o_clear), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .i_ready(i_ready));

  conv_result_collector #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .KERNEL_SIZE(3), .PIPE_LAT(1)) dut_pl1 (
    .clk(clk), .rst(rst), .i_pixel_bus(i_pixel_bus), .i_mac_valid(i_mac_valid),
    .o_mac_ready(p1_mac_ready), .o_clear(p1_clear), .o_data(p1_data), .o_valid(p1_valid),
    .o_last(p1_last), .i_ready(1'b1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef CONV_COLLECTOR_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [AS*DW-1:0] bus, input int i);
    return bus[(AS-1-i)*DW +: DW];
  endfunction

  // Reference model: a queue of lanes still owed downstream, a beat count and a drain timer.
  logic [DW-1:0] q[$];
  int  m_beats = 0, m_dcnt = 0;
  bit  m_drain = 0, m_clear = 0;
  bit  e_ready, e_valid, hs, cap;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mac_ready", o_mac_ready, 0);
      chk("rst_clear", o_clear, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_last", o_last, 0);
      chk("rst_data", o_data, 0);
      m_beats = 0; m_dcnt = 0; m_drain = 0; m_clear = 0;
      q.delete();
    end else begin
      e_ready = !m_drain && !m_clear;
      e_valid = q.size() != 0;
      chk("m_mac_ready", o_mac_ready, e_ready);
      chk("m_clear", o_clear, m_clear);
      chk("m_valid", o_valid, e_valid);
      if (e_valid) begin
        chk("m_data", o_data, q[0]);
        chk("m_last", o_last, q.size() == 1);
      end
      hs  = e_valid && i_ready;
      cap = m_drain && m_dcnt >= PL - 1 && (q.size() == 0 || (q.size() == 1 && i_ready));
      if (hs) void'(q.pop_front());
      if (cap) begin
        for (int i = 0; i < AS; i++) q.push_back(relu(lane_of(i_pixel_bus, i)));
        m_drain = 0;
      end else if (m_drain) begin
        m_dcnt++;
      end
      if (e_ready && i_mac_valid) begin
        m_beats++;
        if (m_beats == KK) begin
          m_beats = 0; m_drain = 1; m_dcnt = 0;
        end
      end
      m_clear = cap;
    end
  end

  typedef struct {
    logic [AS*DW-1:0] bus;
    logic [AS*DW-1:0] exp;
  } vec_t;
  vec_t vecs [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [AS*DW-1:0] bus, input logic [AS*DW-1:0] exp);
    i_pixel_bus = bus;
    i_ready     = 1'b1;
    for (int k = 0; k < KK; k++) begin
      i_mac_valid = 1'b1;
      step();
    end
    i_mac_valid = 1'b0;
    chk("win_ready_t1", o_mac_ready, 0);
    chk("win_clear_t1", o_clear, 0);
    step();
    chk("win_clear_t2", o_clear, 0);
    chk("win_ready_t2", o_mac_ready, 0);
    chk("pl1_clear_t2", p1_clear, 1);
    chk("pl1_valid_t2", p1_valid, 1);
    chk("pl1_data_t2", p1_data, lane_of(exp, 0));
    step();
    for (int j = 0; j < AS; j++) begin
      chk("win_clear", o_clear, j == 0);
      chk("win_valid", o_valid, 1);
      chk("win_data", o_data, lane_of(exp, j));
      chk("win_last", o_last, j == AS - 1);
      chk("win_ready", o_mac_ready, j >= 1);
      step();
    end
    chk("win_valid_end", o_valid, 0);
  endtask

  logic [AS*DW-1:0] bus_a, bus_b;

  initial begin
    vecs[0].bus = {16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
    vecs[0].exp = vecs[0].bus;
    vecs[1].bus = {16'h8001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h1234};
    vecs[2].bus = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hABCD, 16'h5555};
`ifdef CONV_COLLECTOR_RELU_EN
    vecs[1].exp = {16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0001, 16'h1234};
    vecs[2].exp = {16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h5555};
`else
    vecs[1].exp = vecs[1].bus;
    vecs[2].exp = vecs[2].bus;
`endif

    rst = 1'b1; i_mac_valid = 1'b0; i_ready = 1'b1; i_pixel_bus = '0;
    step(); step();
    chk("reset_mac_ready", o_mac_ready, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_data", o_data, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", o_mac_ready, 1);

    for (int v = 0; v < 3; v++) run_window(vecs[v].bus, vecs[v].exp);

    // Backpressure: window B completes while A is stalled on lane 2.
    bus_a = {16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05};
    bus_b = {16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05};
    i_pixel_bus = bus_a; i_ready = 1'b1;
    for (int k = 0; k < KK; k++) begin i_mac_valid = 1'b1; step(); end
    i_mac_valid = 1'b0;
    step(); step(); step(); step();
    i_ready = 1'b0; i_pixel_bus = bus_b; i_mac_valid = 1'b1;
    chk("bp_lane2", o_data, relu(16'h0A02));
    for (int k = 0; k < KK; k++) step();
    i_mac_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_data", o_data, relu(16'h0A02));
      chk("bp_hold_clear", o_clear, 0);
      chk("bp_hold_ready", o_mac_ready, 0);
      step();
    end
    i_ready = 1'b1;
    for (int j = 2; j < AS; j++) begin
      chk("bp_a_data", o_data, relu(lane_of(bus_a, j)));
      chk("bp_a_last", o_last, j == AS - 1);
      step();
    end
    chk("bp_b_clear", o_clear, 1);
    chk("bp_b_valid", o_valid, 1);
    chk("bp_b_lane0", o_data, relu(16'h0B00));
    for (int k = 0; k < 8; k++) step();

    // Reset during lane 3 of serialization.
    i_pixel_bus = vecs[1].bus;
    for (int k = 0; k < KK; k++) begin i_mac_valid = 1'b1; step(); end
    i_mac_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("rs_lane3", o_data, lane_of(vecs[1].exp, 3));
    rst = 1'b1;
    #1;
    chk("rs_valid", o_valid, 0);
    chk("rs_ready", o_mac_ready, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rs_ready_after", o_mac_ready, 1);
    chk("rs_valid_after", o_valid, 0);
    for (int k = 0; k < KK - 1; k++) begin i_mac_valid = 1'b1; step(); end
    i_mac_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("rs_partial_ready", o_mac_ready, 1);
      chk("rs_partial_clear", o_clear, 0);
      step();
    end
    i_mac_valid = 1'b1; step(); i_mac_valid = 1'b0;
    chk("rs_full_drain", o_mac_ready, 0);
    for (int k = 0; k < 10; k++) step();

    // Gapped beats, offers continuing during drain and clear.
    for (int k = 0; k < 60; k++) begin
      i_mac_valid = k[0] ? 1'b0 : 1'b1;
      i_pixel_bus = {$urandom, $urandom, $urandom};
      step();
    end

    // Randomized traffic, with an occasional reset.
    for (int k = 0; k < 3000; k++) begin
      i_mac_valid = ($urandom % 4) != 0;
      i_ready     = ($urandom % 3) != 0;
      i_pixel_bus = {$urandom, $urandom, $urandom};
      rst         = ($urandom % 400) == 0;
      step();
    end
    rst = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
